// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the serial system-bus master port:
//                controller state encoding, slave-select cycle count and the
//                slave-select codes carried on cmd_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SEL   = 3'd2,
        ST_CONN  = 3'd3,
        ST_ADDR  = 3'd4,
        ST_WDATA = 3'd5,
        ST_RDATA = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Number of bus cycles used to present the slave select
    localparam int SEL_CYCLES = 3;

    // Slave-select encodings on cmd_slave
    localparam logic [1:0] SLV1 = 2'd0;
    localparam logic [1:0] SLV2 = 2'd1;
    localparam logic [1:0] SLV3 = 2'd2;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_serial_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_serial_shifter
//  Description : Parallel-load, MSB-first shift register with a bit counter.
//                Each shift presents the next bit on o_bit and captures
//                i_serial_in at the LSB, so the same register serves both
//                serialisation and deserialisation.
//  Ports       : clk/reset     - clock, synchronous active-high reset
//                i_load        - load i_load_data, clear bit counter
//                i_shift       - advance one bit (ignored while loading)
//                i_serial_in   - bit captured at the LSB on each shift
//                i_last_idx    - bit index at which o_done is flagged
//                o_data        - full register contents
//                o_bit         - bit currently presented (MSB)
//                o_done        - current bit is the one at i_last_idx
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_serial_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_serial_in,
    input  logic [CNT_W-1:0] i_last_idx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bit,
    output logic             o_done
);

    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_data_d = r_data_q;
        w_cnt_d  = r_cnt_q;
        if (i_load) begin
            w_data_d = i_load_data;
            w_cnt_d  = '0;
        end else if (i_shift) begin
            w_data_d = {r_data_q[WIDTH-2:0], i_serial_in};
            w_cnt_d  = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_q <= '0;
            r_cnt_q  <= '0;
        end else begin
            r_data_q <= w_data_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign o_data = r_data_q;
    assign o_bit  = r_data_q[WIDTH-1];
    assign o_done = (r_cnt_q == i_last_idx);

endmodule : bus_serial_shifter
`default_nettype wire

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_port
//  Description : Master-side controller for the shared serial system bus.
//                Accepts one read/write command from the core, runs the
//                request / slave-select / address / data bit sequence,
//                tolerates arbiter split periods (m_available=0) and returns
//                a one-cycle response with optional timeout error.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                cmd_*               - core command handshake and payload
//                rsp_*               - one-cycle completion response
//                m_* (outputs)       - serial bus master drive
//                m_data_in, m_valid_in, m_ready, m_available - bus inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_slave,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  m_request,
    output logic                  m_address_valid,
    output logic                  m_valid,
    output logic                  m_address,
    output logic                  m_data,
    output logic                  m_write_en,
    output logic                  m_burst,
    input  logic                  m_data_in,
    input  logic                  m_valid_in,
    input  logic                  m_ready,
    input  logic                  m_available
);

    // The address path carries the slave select followed by the local address
    localparam int AW   = SEL_CYCLES + ADDR_WIDTH;
    localparam int A_CW = $clog2(AW + 1);
    localparam int D_CW = $clog2(DATA_WIDTH + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [A_CW-1:0] C_SEL_LAST  = A_CW'(SEL_CYCLES - 1);
    localparam logic [A_CW-1:0] C_ADDR_LAST = A_CW'(AW - 1);
    localparam logic [D_CW-1:0] C_DATA_LAST = D_CW'(DATA_WIDTH - 1);
    // Counter value on the final permitted waiting cycle
    localparam logic [TW-1:0]   C_TMO_LAST  = TW'(TIMEOUT - 1);

    state_t          r_state_q;
    state_t          w_state_d;
    logic            r_write_q;
    logic            w_write_d;
    logic            r_err_q;
    logic            w_err_d;
    logic [TW-1:0]   r_tmo_q;
    logic [TW-1:0]   w_tmo_d;

    logic            w_accept;
    logic            w_a_shift;
    logic            w_d_shift;
    logic            w_a_bit;
    logic            w_a_done;
    logic [A_CW-1:0] w_a_last_idx;
    logic [AW-1:0]   w_a_load_data;
    logic [AW-1:0]   w_a_data;
    logic            w_d_bit;
    logic            w_d_done;
    logic [DATA_WIDTH-1:0] w_d_data;

    // Slave select is sent as {s[1], s[1], s[0]} ahead of the address bits
    assign w_a_load_data = {cmd_slave[1], cmd_slave[1], cmd_slave[0], cmd_addr};
    assign w_a_last_idx  = (r_state_q == ST_SEL) ? C_SEL_LAST : C_ADDR_LAST;

    bus_serial_shifter #(
        .WIDTH (AW),
        .CNT_W (A_CW)
    ) u_addr_path (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_data (w_a_load_data),
        .i_shift     (w_a_shift),
        .i_serial_in (1'b0),
        .i_last_idx  (w_a_last_idx),
        .o_data      (w_a_data),
        .o_bit       (w_a_bit),
        .o_done      (w_a_done)
    );

    bus_serial_shifter #(
        .WIDTH (DATA_WIDTH),
        .CNT_W (D_CW)
    ) u_data_path (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_load_data (cmd_wdata),
        .i_shift     (w_d_shift),
        .i_serial_in (m_data_in),
        .i_last_idx  (C_DATA_LAST),
        .o_data      (w_d_data),
        .o_bit       (w_d_bit),
        .o_done      (w_d_done)
    );

    assign m_burst = 1'b0;

    always_comb begin
        w_state_d       = r_state_q;
        w_write_d       = r_write_q;
        w_err_d         = r_err_q;
        w_tmo_d         = r_tmo_q;
        w_accept        = 1'b0;
        w_a_shift       = 1'b0;
        w_d_shift       = 1'b0;
        cmd_ready       = 1'b0;
        m_request       = 1'b0;
        m_address_valid = 1'b0;
        m_valid         = 1'b0;
        m_address       = 1'b0;
        m_data          = 1'b0;
        m_write_en      = 1'b0;
        rsp_valid       = 1'b0;
        rsp_error       = 1'b0;
        rsp_rdata       = '0;

        case (r_state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept  = 1'b1;
                    w_write_d = cmd_write;
                    w_err_d   = 1'b0;
                    w_state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                m_request       = 1'b1;
                m_address_valid = 1'b1;
                m_write_en      = r_write_q;
                if (m_available) begin
                    w_state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                m_request       = 1'b1;
                m_address_valid = 1'b1;
                m_write_en      = r_write_q;
                m_address       = w_a_bit;
                m_valid         = m_available;
                // A split freezes the bit index so the same bit is re-driven
                if (m_available) begin
                    w_a_shift = 1'b1;
                    if (w_a_done) begin
                        w_tmo_d   = '0;
                        w_state_d = ST_CONN;
                    end
                end
            end
            ST_CONN: begin
                m_request  = 1'b1;
                m_write_en = r_write_q;
                if (m_ready) begin
                    w_state_d = ST_ADDR;
                end else if (m_available) begin
                    if (r_tmo_q == C_TMO_LAST) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end else begin
                        w_tmo_d = r_tmo_q + 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                m_request  = 1'b1;
                m_write_en = r_write_q;
                m_address  = w_a_bit;
                m_valid    = m_available;
                if (m_available) begin
                    w_a_shift = 1'b1;
                    if (w_a_done) begin
                        if (r_write_q) begin
                            w_state_d = ST_WDATA;
                        end else begin
                            w_tmo_d   = '0;
                            w_state_d = ST_RDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                m_request  = 1'b1;
                m_write_en = r_write_q;
                m_data     = w_d_bit;
                m_valid    = m_available;
                if (m_available) begin
                    w_d_shift = 1'b1;
                    if (w_d_done) begin
                        w_state_d = ST_DONE;
                    end
                end
            end
            ST_RDATA: begin
                m_request  = 1'b1;
                m_write_en = r_write_q;
                // m_valid_in is only honoured while the bus is available
                if (m_available) begin
                    if (m_valid_in) begin
                        w_d_shift = 1'b1;
                        w_tmo_d   = '0;
                        if (w_d_done) begin
                            w_state_d = ST_DONE;
                        end
                    end else if (r_tmo_q == C_TMO_LAST) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end else begin
                        w_tmo_d = r_tmo_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_error = r_err_q;
                rsp_rdata = (r_err_q || r_write_q) ? '0 : w_d_data;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_write_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_tmo_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_write_q <= w_write_d;
            r_err_q   <= w_err_d;
            r_tmo_q   <= w_tmo_d;
        end
    end

    // Only the MSB of the address path is driven onto the bus
    logic w_a_unused;
    assign w_a_unused = ^w_a_data[AW-2:0];

endmodule : bus_master_port
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_master_port
//  Description : Directed self-checking bench for bus_master_port using
//                hand-computed bit streams and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_port;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_slave;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic        m_request;
    logic        m_address_valid;
    logic        m_valid;
    logic        m_address;
    logic        m_data;
    logic        m_write_en;
    logic        m_burst;
    logic        m_data_in;
    logic        m_valid_in;
    logic        m_ready;
    logic        m_available;

    int n_assert = 0;
    int n_fail   = 0;

    bus_master_port #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8),
        .TIMEOUT    (255)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_slave       (cmd_slave),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .m_request       (m_request),
        .m_address_valid (m_address_valid),
        .m_valid         (m_valid),
        .m_address       (m_address),
        .m_data          (m_data),
        .m_write_en      (m_write_en),
        .m_burst         (m_burst),
        .m_data_in       (m_data_in),
        .m_valid_in      (m_valid_in),
        .m_ready         (m_ready),
        .m_available     (m_available)
    );

    always #5 clk = ~clk;

    // Start of a cycle: just after the rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow newly driven inputs before sampling
    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to rsp_valid (bounded at 400 cycles).
    // Cycle offsets k are relative to the acceptance cycle A.
    task automatic run_cmd(
        input  logic        wr,
        input  logic [1:0]  slv,
        input  logic [11:0] addr,
        input  logic [7:0]  wd,
        input  logic [7:0]  rd_val,
        input  logic        feed,
        input  int          split_at,
        input  int          split_len,
        input  logic        hold,
        output int          lat,
        output logic [22:0] stream,
        output int          nvalid,
        output logic [7:0]  rdata,
        output logic        err,
        output logic        req_done,
        output int          viol,
        output logic [4:0]  snap
    );
        int   rd_cyc;
        int   rd_bits;
        logic rd_phase;
        logic done;
        lat = -1; stream = '0; nvalid = 0; rdata = '0; err = 1'b0;
        req_done = 1'b1; viol = 0; snap = '0;
        rd_cyc = 0; rd_bits = 0; rd_phase = 1'b0; done = 1'b0;

        tick();
        cmd_valid = 1'b1; cmd_write = wr; cmd_slave = slv;
        cmd_addr  = addr; cmd_wdata = wd;
        settle();
        if (!cmd_ready) viol++;

        for (int k = 1; k <= 400 && !done; k++) begin
            tick();
            cmd_valid   = hold;
            m_available = !(k >= split_at && k < split_at + split_len);
            m_valid_in  = 1'b0;
            m_data_in   = 1'b0;
            // Read bits delivered with one idle cycle between them
            if (rd_phase && feed && rd_bits < 8) begin
                if (rd_cyc % 2 == 0) begin
                    m_valid_in = 1'b1;
                    m_data_in  = rd_val[7 - rd_bits];
                    rd_bits++;
                end
                rd_cyc++;
            end
            settle();
            if (k == 1) snap = {m_request, m_address_valid, m_write_en, cmd_ready, m_valid};
            if (cmd_ready) viol++;
            if (!m_available && m_valid) viol++;
            if (m_valid) begin
                if (nvalid < 15)      stream[22 - nvalid] = m_address;
                else if (nvalid < 23) stream[22 - nvalid] = m_data;
                nvalid++;
            end
            if (!wr && nvalid == 15) rd_phase = 1'b1;
            if (rsp_valid) begin
                lat      = k;
                rdata    = rsp_rdata;
                err      = rsp_error;
                req_done = m_request;
                done     = 1'b1;
            end
        end
        m_available = 1'b1;
        m_valid_in  = 1'b0;
        m_data_in   = 1'b0;
    endtask

    int          lat;
    logic [22:0] stream;
    int          nvalid;
    logic [7:0]  rdata;
    logic        err;
    logic        req_done;
    int          viol;
    logic [4:0]  snap;
    int          seen;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slave = 2'd0;
        cmd_addr = '0; cmd_wdata = '0; m_data_in = 1'b0; m_valid_in = 1'b0;
        m_ready = 1'b1; m_available = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        settle();

        // Reset state
        check("reset_outputs",
              {cmd_ready, m_request, m_address_valid, m_valid, m_address, m_data,
               m_write_en, m_burst, rsp_valid, rsp_error}, 10'b10_0000_0000);
        check("reset_rdata", rsp_rdata, 8'h00);

        // Nominal write
        run_cmd(1'b1, SLV3, 12'h0A5, 8'h3C, 8'h00, 1'b0, 0, 0, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("wr_req_snapshot", snap, 5'b11100);
        check("wr_stream", stream, {3'b110, 12'h0A5, 8'h3C});
        check("wr_nvalid", nvalid, 23);
        check("wr_latency", lat, 26);
        check("wr_err_rdata", {err, rdata}, 9'h000);
        check("wr_req_in_done", req_done, 1'b0);
        check("wr_protocol", viol, 0);

        // Nominal read, one idle cycle between returned bits
        run_cmd(1'b0, SLV2, 12'h001, 8'h00, 8'hA7, 1'b1, 0, 0, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("rd_req_snapshot", snap, 5'b11000);
        check("rd_stream", stream, {3'b001, 12'h001, 8'h00});
        check("rd_latency", lat, 33);
        check("rd_rdata", rdata, 8'hA7);
        check("rd_err", err, 1'b0);

        // Split of 5 cycles while write-data bit 3 is on the bus (A+21..A+25)
        run_cmd(1'b1, SLV1, 12'h5A3, 8'h96, 8'h00, 1'b0, 21, 5, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("split_stream", stream, {3'b000, 12'h5A3, 8'h96});
        check("split_latency", lat, 31);
        check("split_no_valid", viol, 0);

        // Timeout waiting for m_ready
        m_ready = 1'b0;
        run_cmd(1'b1, SLV3, 12'h123, 8'h55, 8'h00, 1'b0, 0, 0, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("tmo_conn_latency", lat, 260);
        check("tmo_conn_err_rdata", {err, rdata}, 9'h100);
        check("tmo_conn_req_in_done", req_done, 1'b0);
        check("tmo_conn_nvalid", nvalid, 3);
        m_ready = 1'b1;

        // Timeout waiting for read bits: RDATA entered at A+18
        run_cmd(1'b0, SLV2, 12'h0F0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("tmo_rd_latency", lat, 273);
        check("tmo_rd_err_rdata", {err, rdata}, 9'h100);

        // Reset during ADDR (A+10)
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_slave = SLV3;
        cmd_addr = 12'hABC; cmd_wdata = 8'h0F;
        settle();
        for (int i = 0; i < 10; i++) begin
            tick();
            cmd_valid = 1'b0;
            settle();
        end
        check("rst_mid_in_addr", {m_valid, m_request, m_address_valid}, 3'b110);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("rst_mid_outputs",
              {cmd_ready, m_request, m_address_valid, m_valid, m_address, m_data,
               m_write_en, m_burst, rsp_valid, rsp_error}, 10'b10_0000_0000);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            settle();
            if (rsp_valid) seen++;
        end
        check("rst_mid_no_rsp", seen, 0);
        run_cmd(1'b1, SLV2, 12'h777, 8'hE1, 8'h00, 1'b0, 0, 0, 1'b0,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("rst_after_latency", lat, 26);
        check("rst_after_stream", stream, {3'b001, 12'h777, 8'hE1});

        // cmd_valid held through a transfer
        run_cmd(1'b1, SLV3, 12'h0A5, 8'h3C, 8'h00, 1'b0, 0, 0, 1'b1,
                lat, stream, nvalid, rdata, err, req_done, viol, snap);
        check("hold_latency", lat, 26);
        check("hold_no_accept", viol, 0);
        cmd_write = 1'b1; cmd_slave = SLV1; cmd_addr = 12'h010; cmd_wdata = 8'h81;
        tick();
        settle();
        check("hold_idle_cycle", {cmd_ready, m_request}, 2'b10);
        tick();
        cmd_valid = 1'b0;
        settle();
        check("hold_second_req", {cmd_ready, m_request}, 2'b01);
        lat = -1;
        for (int k = 2; k <= 60 && lat < 0; k++) begin
            tick();
            settle();
            if (rsp_valid) lat = k;
        end
        check("hold_second_latency", lat, 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bus_master_port
`default_nettype wire
